// File: rtl/q_accum.sv
// rtl/q_accum.sv - saturating sign-magnitude Q-format frame accumulator
// Optional feature macro: Q_ACCUM_AVG_EN (rounded right-shift of the frame total by AVG_SHIFT)
module q_accum #(
  parameter int Q         = 15,
  parameter int N         = 32,
  parameter int LEN_W     = 8,
  parameter int AVG_SHIFT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [LEN_W-1:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  // Largest representable magnitude and its negation, in the N+1 bit accumulator domain
  localparam logic signed [N:0] MAX_P = {2'b00, {(N-1){1'b1}}};
  localparam logic signed [N:0] MIN_N = {2'b11, {(N-2){1'b0}}, 1'b1};

  state_t            state;
  logic signed [N:0] acc;
  logic [LEN_W-1:0]  remaining;
  logic              ovf;
  logic              armed;

  logic signed [N:0] smag;
  logic signed [N:0] sample_tc;
  logic signed [N:0] base;
  logic signed [N:0] sum;
  logic signed [N:0] acc_next;
  logic              sat;
  logic              take;
  logic              last;
  logic              neg;
  logic [N-2:0]      mag_lo;
  logic [N-2:0]      mag;
  logic [N-2:0]      rmag;
  logic [N-1:0]      out_word;
`ifdef Q_ACCUM_AVG_EN
  logic [N-1:0]      rnd;
`endif

  // armed keeps in_ready low until the first edge after reset release
  assign in_ready = armed && (state != S_OUT);
  assign take     = in_valid && in_ready;

  // Datapath: convert sample, add with saturation, and pre-format the would-be frame result
  always_comb begin
    smag      = {2'b00, in_data[N-2:0]};
    sample_tc = in_data[N-1] ? -smag : smag;
    base      = (state == S_IDLE) ? '0 : acc;
    sum       = base + sample_tc;
    sat       = 1'b0;
    acc_next  = sum;
    if (sum > MAX_P) begin
      acc_next = MAX_P;
      sat      = 1'b1;
    end else if (sum < MIN_N) begin
      acc_next = MIN_N;
      sat      = 1'b1;
    end
    last   = (state == S_IDLE) ? (len <= LEN_W'(1)) : (remaining == LEN_W'(1));
    neg    = acc_next[N];
    mag_lo = acc_next[N-2:0];
    mag    = neg ? (~mag_lo + (N-1)'(1)) : mag_lo;
`ifdef Q_ACCUM_AVG_EN
    rnd  = {1'b0, mag} + (N'(1) << (AVG_SHIFT - 1));
    rmag = (N-1)'(rnd >> AVG_SHIFT);
`else
    rmag = mag;
`endif
    // A zero magnitude is always emitted with a positive sign
    out_word = {neg && (rmag != '0), rmag};
  end

  // Frame FSM with registered result port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
      armed     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (take) begin
            acc       <= acc_next;
            ovf       <= 1'b0;
            remaining <= (len == '0) ? '0 : len - LEN_W'(1);
            if (last) begin
              state     <= S_OUT;
              out_valid <= 1'b1;
              out_data  <= out_word;
              out_ovf   <= 1'b0;
            end else begin
              state <= S_ACC;
            end
          end
        end
        S_ACC: begin
          if (take) begin
            acc       <= acc_next;
            ovf       <= ovf | sat;
            remaining <= remaining - LEN_W'(1);
            if (last) begin
              state     <= S_OUT;
              out_valid <= 1'b1;
              out_data  <= out_word;
              out_ovf   <= ovf | sat;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q_accum.sv
// tb/tb_q_accum.sv - self-checking bench for q_accum
module tb_q_accum;

  localparam int N         = 32;
  localparam int AVG_SHIFT = 3;
  localparam int CYC_MAX   = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [7:0]  len = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  q_accum #(.Q(15), .N(N), .LEN_W(8), .AVG_SHIFT(AVG_SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .len(len), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       l;
    logic [7:0][31:0] s;
    logic [31:0]      ed;
    logic             eo;
  } vec_t;

  vec_t vecs[8];
  int   n_vecs;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: integer sum with clamping, then sign-magnitude (optionally rounded average)
  function automatic logic [32:0] model(input logic [7:0][31:0] s, input int n);
    longint mx = (64'sd1 <<< 31) - 1;
    longint acc = 0;
    longint v;
    longint m;
    logic   ovf = 1'b0;
    logic   sg;
    logic [63:0] mu;
    for (int i = 0; i < n; i++) begin
      v = longint'(s[i][30:0]);
      if (s[i][31]) v = -v;
      acc = acc + v;
      if (acc > mx) begin acc = mx; ovf = 1'b1; end
      if (acc < -mx) begin acc = -mx; ovf = 1'b1; end
    end
    sg = (acc < 0);
    m  = sg ? -acc : acc;
`ifdef Q_ACCUM_AVG_EN
    m = (m + (64'sd1 <<< (AVG_SHIFT - 1))) >>> AVG_SHIFT;
`endif
    if (m == 0) sg = 1'b0;
    mu = 64'(m);
    return {ovf, sg, mu[30:0]};
  endfunction

  task automatic push_one(input string nm, input logic [31:0] d, input logic [7:0] l);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    len      = l;
    while (!in_ready && t < CYC_MAX) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk({nm, " ready_timeout"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic run_frame(input string nm, input logic [7:0] l, input logic [7:0][31:0] s,
                           input int gap, input int odly, input logic [31:0] ed, input logic eo);
    int n = (l == 0) ? 1 : int'(l);
    for (int i = 0; i < n; i++) begin
      // later len values must be ignored, so scramble them
      push_one(nm, s[i], (i == 0) ? l : 8'($urandom));
      if (i < n - 1) begin
        chk({nm, " valid_early"}, 32'(out_valid), 32'd0);
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    chk({nm, " valid"}, 32'(out_valid), 32'd1);
    chk({nm, " data"}, out_data, ed);
    chk({nm, " ovf"}, 32'(out_ovf), 32'(eo));
    repeat (odly) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " valid_drop"}, 32'(out_valid), 32'd0);
    chk({nm, " ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0][31:0] s;
    logic [32:0]      e;
    logic [31:0]      held;
    logic [7:0]       l;

`ifdef Q_ACCUM_AVG_EN
    vecs[0] = '{8'd8, {8{32'h0000_8000}}, 32'h0000_8000, 1'b0};
    vecs[1] = '{8'd1, {224'd0, 32'h8000_0004}, 32'h8000_0001, 1'b0};
    vecs[2] = '{8'd1, {224'd0, 32'h0000_0003}, 32'h0000_0000, 1'b0};
    vecs[3] = '{8'd2, {192'd0, 32'h0000_0001, 32'h7FFF_FFFF}, 32'h1000_0000, 1'b1};
    vecs[4] = '{8'd1, {224'd0, 32'h8000_0003}, 32'h0000_0000, 1'b0};
    n_vecs  = 5;
`else
    vecs[0] = '{8'd4, {128'd0, 32'h8000_4000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000}, 32'h0001_4000, 1'b0};
    vecs[1] = '{8'd2, {192'd0, 32'h0000_0001, 32'h7FFF_FFFF}, 32'h7FFF_FFFF, 1'b1};
    vecs[2] = '{8'd1, {224'd0, 32'h0000_0001}, 32'h0000_0001, 1'b0};
    vecs[3] = '{8'd2, {192'd0, 32'h0000_4000, 32'h8000_8000}, 32'h8000_4000, 1'b0};
    vecs[4] = '{8'd2, {192'd0, 32'h0000_0000, 32'h8000_0000}, 32'h0000_0000, 1'b0};
    vecs[5] = '{8'd0, {224'd0, 32'h0001_8000}, 32'h0001_8000, 1'b0};
    vecs[6] = '{8'd3, {160'd0, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 32'hFFFF_FFFE, 1'b1};
    n_vecs  = 7;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel in_ready pre-edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rel in_ready", 32'(in_ready), 32'd1);

    // Table vectors
    for (int i = 0; i < n_vecs; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].l, vecs[i].s, 0, 0, vecs[i].ed, vecs[i].eo);

    // Backpressure: result held, nothing accepted while OUT
    s = '0; s[0] = 32'h0001_8000;
    e = model(s, 1);
    push_one("bp", s[0], 8'd1);
    in_valid = 1'b1;
    in_data  = 32'h0000_0005;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp valid%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp data%0d", k), out_data, e[31:0]);
      chk($sformatf("bp ovf%0d", k), 32'(out_ovf), 32'(e[32]));
      chk($sformatf("bp in_ready%0d", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp release", 32'(out_valid), 32'd0);
    s = '0; s[0] = 32'h0000_0002;
    e = model(s, 1);
    run_frame("bp next", 8'd1, s, 0, 0, e[31:0], e[32]);

    // Reset mid-frame discards the partial sum
    push_one("mid", 32'h0000_8000, 8'd4);
    push_one("mid", 32'h0000_8000, 8'd4);
    rst_n = 1'b0;
    #1;
    chk("mid out_valid", 32'(out_valid), 32'd0);
    chk("mid in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    s = '0; s[0] = 32'h0000_8000; s[1] = 32'h0000_8000;
    e = model(s, 2);
    run_frame("after rst", 8'd2, s, 0, 0, e[31:0], e[32]);

    // Input gaps do not change the result
    s = '0; s[0] = 32'h0000_8000; s[1] = 32'h0000_8000; s[2] = 32'h8000_4000;
    e = model(s, 3);
    run_frame("gaps", 8'd3, s, 3, 2, e[31:0], e[32]);

    // Randomized frames against the reference model
    for (int f = 0; f < 40; f++) begin
      l = 8'($urandom_range(0, 8));
      s = '0;
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 3))
          0: held = 32'($urandom_range(0, 32'h0003_FFFF));
          1: held = $urandom & 32'h7FFF_FFFF;
          2: held = 32'h7FFF_FFFF;
          default: held = 32'h0;
        endcase
        held[31] = 1'($urandom);
        s[i] = held;
      end
      e = model(s, (l == 0) ? 1 : int'(l));
      run_frame($sformatf("rnd%0d", f), l, s, $urandom_range(0, 2), $urandom_range(0, 3), e[31:0], e[32]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/q_accum.md
# q_accum

Sequential fixed-point accumulator that sits directly downstream of the qadd/qmult/qdiv arithmetic stage. It consumes one sign-magnitude Q-format result per handshake and sums a frame of `len` samples with per-step saturation. It then presents the frame total, and a sticky overflow flag, on a valid/ready output port. The number format matches the arithmetic stage:

- `N` bits total.
- Bit N-1 is the sign; bits N-2:0 are the magnitude.
- The low `Q` magnitude bits are fractional.

## Interface
- `Q`, 15, fractional bits of the number format.
- `N`, 32, total word width including the sign bit.
- `LEN_W`, 8, width of the frame-length input.
- `AVG_SHIFT`, 3, averaging right-shift. Used only with `Q_ACCUM_AVG_EN`; valid range 1..N-2.
- `clk`  input  1  clock; all logic is rising-edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  upstream sample valid.
- `in_ready`  output  1  block can accept a sample.
- `in_data`  input  N  sign-magnitude Q-format sample.
- `len`  input  LEN_W  samples per frame. Sampled with the first sample of a frame; 0 is treated as 1.
- `out_valid`  output  1  frame result valid.
- `out_ready`  input  1  downstream accepts the result.
- `out_data`  output  N  sign-magnitude frame result.
- `out_ovf`  output  1  saturation occurred during this frame; valid with `out_valid`.

## Operation
- Transfers:
  - Input transfer = `in_valid & in_ready` at a rising edge.
  - Output transfer = `out_valid & out_ready` at a rising edge.
- Internal accumulator: two's complement, N+1 bits. Each sample is converted from sign-magnitude to two's complement before the add.
- Saturation:
  - MAX = 2^(N-1)-1.
  - After every add, a result above +MAX clamps to +MAX and a result below -MAX clamps to -MAX.
  - Any clamp sets the sticky frame flag `ovf`.
- State machine:
  - IDLE: `in_ready`=1. On an input transfer: acc←sample, ovf←0, remaining←max(len,1)-1. Go to OUT if remaining=0, else ACC.
  - ACC: `in_ready`=1. On each input transfer: acc←sat(acc+sample), remaining←remaining-1. On the transfer that makes remaining 0, go to OUT. With no transfer, hold all state.
  - OUT: `in_ready`=0, `out_valid`=1. `out_data` and `out_ovf` are registered and held stable. On an output transfer go to IDLE.
- Output conversion:
  - acc is converted back to sign-magnitude.
  - A zero result is always emitted as +0 (0x0…0). Negative zero is never output.
- Negative-zero input (sign=1, magnitude=0) is accepted and treated as 0.
- `len` changes while a frame is in progress have no effect.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state=IDLE, acc=0, remaining=0.
  - `out_valid`=0, `out_data`=0, `out_ovf`=0.
  - `in_ready`=0 while `rst_n` is low; it reads 1 from the first clock edge after release.
- Reset mid-frame discards the partial sum. The next accepted sample starts a new frame.
- `out_valid` rises on the clock edge that accepts the last sample of a frame, so the result is visible one cycle after that sample's transfer.
- OUT lasts at least one cycle. The minimum frame period is max(len,1)+1 cycles. There is no input/output overlap.
- `out_valid` may not drop without an output transfer. `out_data` and `out_ovf` are constant while `out_valid`=1 and `out_ready`=0.
- The outputs are registered, with no combinational path from inputs to outputs. The one exception is `in_ready`, which depends on state and `rst_n` only, never on `in_valid`.

## Configuration
- Macro: `Q_ACCUM_AVG_EN`.
- Defined:
  - `out_data` magnitude = (|acc| + 2^(AVG_SHIFT-1)) >> AVG_SHIFT, which rounds half away from zero.
  - The sign is kept unless the rounded magnitude is 0, in which case the output is +0.
  - `out_ovf` still reports accumulation saturation only.
- Undefined:
  - `out_data` is the raw saturated sum.
  - `AVG_SHIFT` is ignored, and no rounding logic is present.

## Test plan
- Basic sum (Q=15, N=32): len=4; inputs 0x00008000, 0x00008000, 0x00008000, 0x80004000 (1,1,1,-0.5) → `out_data`=0x00014000 (2.5), `out_ovf`=0, `out_valid` one cycle after the 4th transfer.
- Saturation: len=2; inputs 0x7FFFFFFF, 0x00000001 → 0x7FFFFFFF, `out_ovf`=1. The next frame, len=1 with 0x00000001, gives → 0x00000001, `out_ovf`=0.
- Sign and zero:
  - len=2; inputs 0x80008000, 0x00004000 → 0x80004000.
  - len=2; inputs 0x80000000, 0x00000000 → 0x00000000.
  - len=0 with a single 0x00018000 → 0x00018000.
- Backpressure: hold `out_ready`=0 for 5 cycles in OUT → `out_valid`, `out_data` and `out_ovf` stable, `in_ready`=0 throughout, and no sample is consumed. Raise `out_ready` → IDLE next cycle.
- Reset and input gaps:
  - Assert `rst_n` low after 2 of 4 samples → `out_valid`=0 and `in_ready`=0 immediately.
  - After release, a new frame of len=2 with 0x00008000 ×2 → 0x00010000.
  - Deasserting `in_valid` for 3 cycles mid-frame does not change the result.
- Averaging (`Q_ACCUM_AVG_EN`, AVG_SHIFT=3):
  - len=8 of 0x00008000 → 0x00008000.
  - len=1 of 0x80000004 → 0x80000001 (4/8 rounds away from zero).
  - len=1 of 0x00000003 → 0x00000000.
